// File: rtl/riscv_v_pkg.sv
// Shared types for the RISC-V V byte-lane datapath: lane geometry, per-byte
// complement flags, one-hot element size vectors and the sign-flag queue entry.
package riscv_v_pkg;

  localparam int unsigned BYTE_WIDTH             = 8;
  localparam int unsigned RISCV_V_NUM_BYTES_DATA = 8;
  localparam int unsigned RISCV_V_NUM_OSIZE      = 4;  // 8/16/32/64-bit elements

  typedef logic [RISCV_V_NUM_BYTES_DATA-1:0] riscv_v_complement_t;
  typedef logic [RISCV_V_NUM_OSIZE-1:0]      osize_vector_t;
  typedef logic [RISCV_V_NUM_BYTES_DATA-2:0] riscv_v_merge_data_t;

  typedef struct packed {
    riscv_v_complement_t comp;
    osize_vector_t       osize;
  } riscv_v_sign_entry_t;

  // Bit i set means byte lane i carries into lane i+1 (same element).
  // A non-one-hot size vector yields the OR of each size's boundaries.
  function automatic riscv_v_merge_data_t riscv_v_osize_merge(input osize_vector_t osize);
    riscv_v_merge_data_t merge;
    merge = '0;
    for (int unsigned s = 0; s < RISCV_V_NUM_OSIZE; s++) begin
      for (int unsigned i = 0; i < RISCV_V_NUM_BYTES_DATA - 1; i++) begin
        if (osize[s] && (((i + 32'd1) & ((32'd1 << s) - 32'd1)) != 32'd0)) begin
          merge[i] = 1'b1;
        end
      end
    end
    return merge;
  endfunction

endpackage

// File: rtl/riscv_v_sign_fifo.sv
// Sign-flag queue: DEPTH entries of {complement flags, element size},
// wrapping read/write pointers, occupancy count and synchronous flush.
module riscv_v_sign_fifo
  import riscv_v_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic                push_i,
  input  logic                pop_i,
  input  riscv_v_sign_entry_t wdata_i,
  output riscv_v_sign_entry_t rdata_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [CNT_W-1:0]    occupancy_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  riscv_v_sign_entry_t mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    occ_q, occ_d;
  logic                do_push, do_pop;

  assign full_o      = (occ_q == CNT_W'(DEPTH));
  assign empty_o     = (occ_q == '0);
  assign occupancy_o = occ_q;
  assign rdata_o     = mem_q[rd_ptr_q];

  // Full check uses registered occupancy, so a same-cycle pop never frees a slot.
  assign do_push = push_i & ~full_o  & ~flush_i;
  assign do_pop  = pop_i  & ~empty_o & ~flush_i;

  // Pointer and occupancy next state; flush empties the queue.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
      if (do_pop)  rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
      case ({do_push, do_pop})
        2'b10:   occ_d = CNT_W'(occ_q + 1'b1);
        2'b01:   occ_d = CNT_W'(occ_q - 1'b1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Entry storage; contents beyond occupancy are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/riscv_v_sign_restore_pipe.sv
// Re-applies operand signs to unsigned mul/div results: pops one queued
// flag entry per accepted result, negates flagged elements and registers
// the signed result behind a valid/ready output stage.
module riscv_v_sign_restore_pipe
  import riscv_v_pkg::*;
#(
  parameter  int unsigned BLOCK_WIDTH = BYTE_WIDTH,
  parameter  int unsigned DEPTH       = 4,
  localparam int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                flush,
  input  logic                                                sign_valid,
  output logic                                                sign_ready,
  input  riscv_v_complement_t                                 sign_complement,
  input  osize_vector_t                                       sign_osize,
  input  logic                                                res_valid,
  output logic                                                res_ready,
  input  logic [RISCV_V_NUM_BYTES_DATA-1:0][BLOCK_WIDTH-1:0]  res_data,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [RISCV_V_NUM_BYTES_DATA-1:0][BLOCK_WIDTH-1:0]  out_data,
  output logic [CNT_W-1:0]                                    occupancy
);

  riscv_v_sign_entry_t wr_entry, head;
  logic                fifo_full, fifo_empty, accept;
  logic [RISCV_V_NUM_BYTES_DATA-1:0]                 cont;
  logic [RISCV_V_NUM_BYTES_DATA-1:0][BLOCK_WIDTH-1:0] neg_data;
  logic                                              out_valid_q, out_valid_d;
  logic [RISCV_V_NUM_BYTES_DATA-1:0][BLOCK_WIDTH-1:0] out_data_q, out_data_d;

  assign wr_entry = '{comp: sign_complement, osize: sign_osize};

  riscv_v_sign_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .push_i      (sign_valid),
    .pop_i       (accept),
    .wdata_i     (wr_entry),
    .rdata_o     (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .occupancy_o (occupancy)
  );

  // No empty bypass: a result can only pair with a flag already registered.
  assign sign_ready = ~fifo_full;
  assign res_ready  = ~fifo_empty & (~out_valid_q | out_ready);
  assign accept     = res_valid & res_ready;

  // cont[i]: lane i continues the element that started below it.
  assign cont = {riscv_v_osize_merge(head.osize), 1'b0};

  // Per-element two's complement; flag and carry restart at each element's low byte.
  always_comb begin : negate
    logic                 flag;
    logic                 carry;
    logic [BLOCK_WIDTH:0] sum;
    flag     = 1'b0;
    carry    = 1'b1;
    sum      = '0;
    neg_data = '0;
    for (int unsigned i = 0; i < RISCV_V_NUM_BYTES_DATA; i++) begin
      if (!cont[i]) begin
        flag  = head.comp[i];
        carry = 1'b1;
      end
      sum         = {1'b0, ~res_data[i]} + {{BLOCK_WIDTH{1'b0}}, carry};
      neg_data[i] = flag ? sum[BLOCK_WIDTH-1:0] : res_data[i];
      carry       = sum[BLOCK_WIDTH];
    end
  end

  // Output stage next state: flush clears, accept loads, handshake drains.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = neg_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  a_osize_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    (sign_valid && sign_ready && !flush) |-> $onehot(sign_osize));

endmodule

// File: tb/tb_riscv_v_sign_restore_pipe.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios pinned with literal expectations, then random traffic.
module tb_riscv_v_sign_restore_pipe;
  import riscv_v_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic            clk, rst_n, flush;
  logic            sign_valid, sign_ready;
  logic [7:0]      sign_complement;
  logic [3:0]      sign_osize;
  logic            res_valid, res_ready;
  logic [7:0][7:0] res_data;
  logic            out_valid, out_ready;
  logic [7:0][7:0] out_data;
  logic [2:0]      occupancy;

  riscv_v_sign_restore_pipe #(
    .BLOCK_WIDTH (8),
    .DEPTH       (DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .sign_valid      (sign_valid),
    .sign_ready      (sign_ready),
    .sign_complement (sign_complement),
    .sign_osize      (sign_osize),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_data        (res_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .occupancy       (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] comp;
    logic [3:0] osize;
  } ent_t;

  ent_t        mq[$];
  bit          m_ov;
  logic [63:0] m_od;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed result from element arithmetic: flagged elements become 2^W - v.
  function automatic logic [63:0] restore(input logic [63:0] d, input logic [7:0] comp,
                                          input logic [3:0] osz);
    int unsigned nb;
    logic [63:0] mask, v, r;
    nb = 1;
    r  = '0;
    for (int s = 0; s < 4; s++) if (osz[s]) nb = 1 << s;
    mask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
    for (int unsigned lo = 0; lo < 8; lo += nb) begin
      v = (d >> (8 * lo)) & mask;
      if (comp[lo]) v = (64'd0 - v) & mask;
      r |= v << (8 * lo);
    end
    return r;
  endfunction

  // Compare DUT against model with current inputs, then advance one clock.
  task automatic cycle();
    int unsigned n;
    bit acc, psh;
    #1;
    chk("sign_ready", sign_ready, mq.size() != DEPTH);
    chk("res_ready", res_ready, (mq.size() != 0) && (!m_ov || out_ready));
    chk("out_valid", out_valid, m_ov);
    chk("occupancy", occupancy, mq.size());
    if (m_ov) chk("out_data", out_data, m_od);
    @(posedge clk);
    n = mq.size();
    if (flush) begin
      mq.delete();
      m_ov = 1'b0;
      m_od = '0;
    end else begin
      acc = res_valid && (n != 0) && (!m_ov || out_ready);
      psh = sign_valid && (n != DEPTH);
      if (acc) begin
        m_od = restore(res_data, mq[0].comp, mq[0].osize);
        void'(mq.pop_front());
        m_ov = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (psh) mq.push_back('{sign_complement, sign_osize});
    end
    @(negedge clk);
  endtask

  task automatic idle();
    sign_valid = 1'b0;
    res_valid  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic push(input logic [7:0] comp, input logic [3:0] osz);
    sign_valid      = 1'b1;
    sign_complement = comp;
    sign_osize      = osz;
    cycle();
    sign_valid      = 1'b0;
  endtask

  task automatic push_rand(input int unsigned cnt);
    for (int unsigned k = 0; k < cnt; k++)
      push(8'($urandom), 4'(1 << $urandom_range(0, 3)));
  endtask

  logic [63:0] t3_in  [3];
  logic [63:0] t3_exp [3];

  initial begin
    rst_n = 1'b0; out_ready = 1'b1;
    sign_complement = '0; sign_osize = 4'b0001; res_data = '0;
    idle();
    m_ov = 1'b0; m_od = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_sign_ready", sign_ready, 1);
    chk("rst_res_ready", res_ready, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Byte elements: negate lanes 0,2,3; lane2 is most-negative, lane3 zero.
    push(8'h0D, 4'b0001);
    res_valid = 1'b1; res_data = 64'h0000_0000_0080_0505;
    cycle();
    res_valid = 1'b0;
    #1;
    chk("t2_out_valid", out_valid, 1);
    chk("t2_out_data", out_data, 64'h0000_0000_0080_05FB);

    // Wide elements: carry crosses bytes inside an element only.
    t3_in[0] = 64'h1234_5678_9ABC_0001; t3_exp[0] = 64'h1234_5678_9ABC_FFFF;
    t3_in[1] = 64'h0000_0000_8000_0000; t3_exp[1] = 64'h0000_0000_8000_0000;
    t3_in[2] = 64'h0000_0001_0000_0100; t3_exp[2] = 64'hFFFF_FFFF_FFFF_FF00;
    push(8'h01, 4'b0010);
    push(8'h11, 4'b0100);
    push(8'h11, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      res_valid = 1'b1; res_data = t3_in[i];
      cycle();
      #1;
      chk($sformatf("t3_out_data%0d", i), out_data, t3_exp[i]);
    end
    res_valid = 1'b0;
    cycle();

    // Full queue: same-cycle pop does not admit a push.
    push_rand(DEPTH);
    #1;
    chk("t4_sign_ready_full", sign_ready, 0);
    chk("t4_occupancy_full", occupancy, DEPTH);
    sign_valid = 1'b1; sign_complement = 8'hFF; sign_osize = 4'b1000;
    res_valid = 1'b1; res_data = {$urandom, $urandom};
    cycle();
    res_valid = 1'b0;
    #1;
    chk("t4_occupancy_after_pop", occupancy, DEPTH - 1);
    cycle();
    sign_valid = 1'b0;
    #1;
    chk("t4_occupancy_refill", occupancy, DEPTH);

    // Backpressure then back-to-back drain in FIFO order.
    out_ready = 1'b0; res_valid = 1'b1; res_data = {$urandom, $urandom};
    cycle();
    for (int i = 0; i < 3; i++) begin
      res_data = {$urandom, $urandom};
      cycle();
      #1;
      chk("t5_res_ready_stalled", res_ready, 0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      res_data = {$urandom, $urandom};
      cycle();
      #1;
      chk("t5_out_valid_stream", out_valid, 1);
    end
    res_valid = 1'b0;
    cycle();

    // Flush with a push in the same cycle.
    push_rand(3);
    out_ready = 1'b0; res_valid = 1'b1; res_data = {$urandom, $urandom};
    cycle();
    res_valid = 1'b0;
    flush = 1'b1; sign_valid = 1'b1; sign_osize = 4'b0001;
    cycle();
    idle();
    #1;
    chk("t6_occupancy", occupancy, 0);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_res_ready", res_ready, 0);
    out_ready = 1'b1;
    cycle();

    // Asynchronous reset mid-stream with entries queued.
    push_rand(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_out_valid", out_valid, 0);
    chk("t1_occupancy", occupancy, 0);
    chk("t1_sign_ready", sign_ready, 1);
    chk("t1_res_ready", res_ready, 0);
    mq.delete(); m_ov = 1'b0; m_od = '0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      sign_valid      = 1'($urandom_range(0, 1));
      sign_complement = 8'($urandom);
      sign_osize      = 4'(1 << $urandom_range(0, 3));
      res_valid       = 1'($urandom_range(0, 1));
      res_data        = {$urandom, $urandom};
      out_ready       = ($urandom_range(0, 3) != 0);
      flush           = ($urandom_range(0, 63) == 0);
      cycle();
    end
    idle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
